// File: rtl/pt2262_word_encoder.sv
// PT2262-style frame generator: serialises a latched N_TRITS code word plus a
// sync bit onto dout, with all timing counted in alpha ticks from the divider.
module pt2262_word_encoder #(
  parameter int unsigned N_TRITS   = 12,
  parameter int unsigned MIN_WORDS = 4,
  parameter int unsigned SYNC_LEN  = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 te,
  input  logic [2*N_TRITS-1:0] code,
  output logic                 dout,
  output logic                 busy,
  output logic                 word_done
);

  localparam int unsigned CODE_W  = 2 * N_TRITS;
  localparam int unsigned TRIT_W  = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;
  localparam int unsigned A_W     = 5;
  localparam int unsigned S_W     = $clog2(SYNC_LEN);
  localparam int unsigned WORDS_W = $clog2(MIN_WORDS + 1);

  localparam logic [A_W-1:0]     A_LAST      = A_W'(31);
  localparam logic [TRIT_W-1:0]  TRIT_LAST   = TRIT_W'(N_TRITS - 1);
  localparam logic [S_W-1:0]     S_LAST      = S_W'(SYNC_LEN - 1);
  localparam logic [WORDS_W:0]   MIN_WORDS_X = (WORDS_W + 1)'(MIN_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIT = 2'd1,
    ST_SYNC = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic [TRIT_W-1:0]   trit_q,      trit_d;
  logic [A_W-1:0]      a_q,         a_d;
  logic [S_W-1:0]      s_q,         s_d;
  logic [WORDS_W-1:0]  words_q,     words_d;
  logic [CODE_W-1:0]   shadow_q,    shadow_d;
  logic                dout_q,      dout_d;
  logic                busy_q,      busy_d;
  logic                word_done_q, word_done_d;

  logic [WORDS_W:0]    words_inc;

  // Pick trit t out of the shadowed code word.
  function automatic logic [1:0] sel_trit(input logic [CODE_W-1:0] sh,
                                          input logic [TRIT_W-1:0] t);
    logic [1:0] sym;
    sym = 2'b00;
    for (int i = 0; i < int'(N_TRITS); i++) begin
      if (t == TRIT_W'(i)) begin
        sym = sh[2*i +: 2];
      end
    end
    return sym;
  endfunction

  // Output level for a given state/counter snapshot. Each trit is two 16-alpha
  // halves; a half starts with a 4-alpha pulse that '1' (first half) or
  // '1'/'F' (second half) stretch to 12 alpha. Reserved 10 falls out as 'F'.
  function automatic logic wave_bit(input state_e            st,
                                    input logic [TRIT_W-1:0] t,
                                    input logic [A_W-1:0]    a,
                                    input logic [S_W-1:0]    s,
                                    input logic [CODE_W-1:0] sh);
    logic [1:0] sym;
    logic       long_first;
    logic       long_second;
    logic       half_hi;
    logic       bit_out;
    sym         = sel_trit(sh, t);
    long_first  = (sym == 2'b11);
    long_second = (sym != 2'b00);
    bit_out     = 1'b0;
    case (st)
      ST_TRIT: begin
        half_hi = (a[3:0] < 4'd4) ||
                  ((a[4] ? long_second : long_first) && (a[3:0] < 4'd12));
        bit_out = half_hi;
      end
      ST_SYNC: bit_out = (s < S_W'(4));
      default: bit_out = 1'b0;
    endcase
    return bit_out;
  endfunction

  // State and counter registers; everything else is decided combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      trit_q      <= '0;
      a_q         <= '0;
      s_q         <= '0;
      words_q     <= '0;
      shadow_q    <= '0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      trit_q      <= trit_d;
      a_q         <= a_d;
      s_q         <= s_d;
      words_q     <= words_d;
      shadow_q    <= shadow_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      word_done_q <= word_done_d;
    end
  end

  assign words_inc = {1'b0, words_q} + (WORDS_W + 1)'(1);

  // Next-state: only tick edges advance; non-tick edges hold and clear word_done.
  always_comb begin
    state_d     = state_q;
    trit_d      = trit_q;
    a_d         = a_q;
    s_d         = s_q;
    words_d     = words_q;
    shadow_d    = shadow_q;
    word_done_d = 1'b0;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (te) begin
            shadow_d = code;
            state_d  = ST_TRIT;
            trit_d   = '0;
            a_d      = '0;
            s_d      = '0;
            words_d  = '0;
          end
        end

        ST_TRIT: begin
          if (a_q == A_LAST) begin
            a_d = '0;
            if (trit_q == TRIT_LAST) begin
              state_d = ST_SYNC;
              trit_d  = '0;
              s_d     = '0;
            end else begin
              trit_d = trit_q + TRIT_W'(1);
            end
          end else begin
            a_d = a_q + A_W'(1);
          end
        end

        ST_SYNC: begin
          if (s_q == S_LAST) begin
            word_done_d = 1'b1;
            s_d         = '0;
            if (words_inc <= MIN_WORDS_X) begin
              words_d = words_inc[WORDS_W-1:0];
            end
            // Old count + 1 is the number of words finished with this edge.
            if (te || (words_inc < MIN_WORDS_X)) begin
              shadow_d = code;
              state_d  = ST_TRIT;
              trit_d   = '0;
              a_d      = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          trit_d  = '0;
          a_d     = '0;
          s_d     = '0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    dout_d = wave_bit(state_d, trit_d, a_d, s_d, shadow_d);
  end

  assign dout      = dout_q;
  assign busy      = busy_q;
  assign word_done = word_done_q;

endmodule

// File: tb/tb_pt2262_word_encoder.sv
// Self-checking bench for pt2262_word_encoder: random tick spacing and codes,
// compared word by word against a waveform model built from pulse durations.
module tb_pt2262_word_encoder;

  localparam int unsigned N_TRITS   = 12;
  localparam int unsigned MIN_WORDS = 4;
  localparam int unsigned SYNC_LEN  = 128;
  localparam int unsigned CW        = 2 * N_TRITS;
  localparam int unsigned WLEN      = 32 * N_TRITS + SYNC_LEN;
  localparam int unsigned CHK_W     = WLEN;
  localparam int          MAX_WORDS = 12;

  typedef struct {
    int            word;
    int            k;
    bit            set_te;
    logic          te_val;
    bit            set_code;
    logic [CW-1:0] code_val;
    bit            do_rst;
  } ev_t;

  logic          clk;
  logic          rst;
  logic          tick;
  logic          te;
  logic [CW-1:0] code;
  logic          dout;
  logic          busy;
  logic          word_done;

  int n_tests  = 0;
  int n_fail   = 0;
  int wd_stray = 0;
  int hold_err = 0;
  ev_t evq[$];

  pt2262_word_encoder #(
    .N_TRITS  (N_TRITS),
    .MIN_WORDS(MIN_WORDS),
    .SYNC_LEN (SYNC_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .te       (te),
    .code     (code),
    .dout     (dout),
    .busy     (busy),
    .word_done(word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [CHK_W-1:0] got,
                       input logic [CHK_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected dout for every alpha of one word, from the pulse-width rules.
  function automatic logic [WLEN-1:0] exp_wave(input logic [CW-1:0] c);
    logic [WLEN-1:0] w;
    logic [CW-1:0]   cc;
    int t, a, sym, w1, w2;
    w = '0;
    for (int k = 0; k < int'(WLEN); k++) begin
      if (k < int'(32 * N_TRITS)) begin
        t   = k / 32;
        a   = k % 32;
        cc  = c >> (2 * t);
        sym = int'(cc[1:0]);
        w1  = (sym == 3) ? 12 : 4;
        w2  = (sym == 0) ? 4 : 12;
        w[k] = (a < w1) || (a >= 16 && a < 16 + w2);
      end else begin
        w[k] = (k - int'(32 * N_TRITS)) < 4;
      end
    end
    return w;
  endfunction

  // One alpha tick, then a random idle gap during which outputs must hold.
  task automatic tick_once(output logic d, output logic b, output logic wd);
    int unsigned gap;
    tick = 1'b1;
    @(posedge clk);
    #1;
    d    = dout;
    b    = busy;
    wd   = word_done;
    tick = 1'b0;
    gap  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
      if (word_done !== 1'b0) wd_stray++;
      if (dout !== d || busy !== b) hold_err++;
    end
  endtask

  task automatic apply_events(input int wno, input int k, output logic do_rst);
    do_rst = 1'b0;
    foreach (evq[i]) begin
      if (evq[i].word == wno && evq[i].k == k) begin
        if (evq[i].set_te)   te = evq[i].te_val;
        if (evq[i].set_code) code = evq[i].code_val;
        if (evq[i].do_rst)   do_rst = 1'b1;
      end
    end
  endtask

  task automatic idle_ticks(input string tag, input int n);
    logic d, b, wd, any_d, any_b, any_wd;
    any_d = 1'b0; any_b = 1'b0; any_wd = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick_once(d, b, wd);
      any_d  = any_d | d;
      any_b  = any_b | b;
      any_wd = any_wd | wd;
    end
    check({tag, "_dout"}, CHK_W'(any_d),  CHK_W'(1'b0));
    check({tag, "_busy"}, CHK_W'(any_b),  CHK_W'(1'b0));
    check({tag, "_wd"},   CHK_W'(any_wd), CHK_W'(1'b0));
  endtask

  // Sample 0 is the edge that started the word; tick WLEN is its completion.
  task automatic run_word(input string tag, input int wno, input logic [CW-1:0] exp_code,
                          inout logic d, inout logic b, inout logic wd,
                          output logic cont, output logic aborted);
    logic [WLEN-1:0] wave, bz, wdv;
    logic do_rst, te_now;
    wave = '0; bz = '0; wdv = '0;
    wave[0] = d; bz[0] = b;
    aborted = 1'b0; cont = 1'b0; te_now = te;
    for (int k = 1; k <= int'(WLEN); k++) begin
      apply_events(wno, k, do_rst);
      if (do_rst) begin
        rst = 1'b0;
        #1;
        check($sformatf("%s_w%0d_rst_dout", tag, wno), CHK_W'(dout), CHK_W'(1'b0));
        check($sformatf("%s_w%0d_rst_busy", tag, wno), CHK_W'(busy), CHK_W'(1'b0));
        aborted = 1'b1;
        return;
      end
      te_now = te;
      tick_once(d, b, wd);
      if (k < int'(WLEN)) begin
        wave[k] = d; bz[k] = b; wdv[k] = wd;
      end
    end
    cont = te_now || (wno < int'(MIN_WORDS));
    check($sformatf("%s_w%0d_wave", tag, wno), wave, exp_wave(exp_code));
    check($sformatf("%s_w%0d_busy", tag, wno), bz, {WLEN{1'b1}});
    check($sformatf("%s_w%0d_wd_mid", tag, wno), wdv, '0);
    check($sformatf("%s_w%0d_wd_end", tag, wno), CHK_W'(wd), CHK_W'(1'b1));
    check($sformatf("%s_w%0d_busy_end", tag, wno), CHK_W'(b), CHK_W'(cont));
    check($sformatf("%s_w%0d_dout_end", tag, wno), CHK_W'(d), CHK_W'(cont));
  endtask

  task automatic run_tx(input string tag, output int nwords, output logic aborted);
    logic d, b, wd, cont;
    logic [CW-1:0] cur;
    cur     = code;
    nwords  = 0;
    aborted = 1'b0;
    tick_once(d, b, wd);
    check({tag, "_start_busy"}, CHK_W'(b),  CHK_W'(1'b1));
    check({tag, "_start_wd"},   CHK_W'(wd), CHK_W'(1'b0));
    for (int w = 1; w <= MAX_WORDS; w++) begin
      run_word(tag, w, cur, d, b, wd, cont, aborted);
      if (aborted) return;
      nwords = w;
      if (!cont) break;
      cur = code;
    end
    idle_ticks({tag, "_tail"}, 8);
  endtask

  function automatic ev_t mk_te(input int w, input int k, input logic v);
    ev_t e;
    e = '{word: w, k: k, set_te: 1'b1, te_val: v, set_code: 1'b0,
          code_val: '0, do_rst: 1'b0};
    return e;
  endfunction

  initial begin
    ev_t  e;
    int   n, hold, exp_n;
    logic ab;

    rst = 1'b0; tick = 1'b0; te = 1'b0; code = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", CHK_W'(dout),      CHK_W'(1'b0));
    check("reset_busy", CHK_W'(busy),      CHK_W'(1'b0));
    check("reset_wd",   CHK_W'(word_done), CHK_W'(1'b0));
    rst = 1'b1;

    idle_ticks("idle100", 100);

    // All-zero code, te pulsed for the start tick only.
    code = '0; te = 1'b1;
    evq = {}; evq.push_back(mk_te(1, 1, 1'b0));
    run_tx("zeros", n, ab);
    check("zeros_words", CHK_W'(n), CHK_W'(MIN_WORDS));

    // All-one code, te held for six words, dropped mid word seven.
    code = {CW{1'b1}}; te = 1'b1;
    evq = {}; evq.push_back(mk_te(7, 200, 1'b0));
    run_tx("ones", n, ab);
    check("ones_words", CHK_W'(n), CHK_W'(7));

    // 01 and 10 both encode 'F'.
    code = '0; code[3:0] = 4'b1001; te = 1'b1;
    evq = {}; evq.push_back(mk_te(1, 1, 1'b0));
    run_tx("float", n, ab);
    check("float_words", CHK_W'(n), CHK_W'(MIN_WORDS));

    // Code change mid word 1 only shows up from word 2.
    code = CW'($urandom); te = 1'b1;
    evq = {}; evq.push_back(mk_te(1, 1, 1'b0));
    e = '{word: 1, k: 100, set_te: 1'b0, te_val: 1'b0, set_code: 1'b1,
          code_val: CW'($urandom), do_rst: 1'b0};
    evq.push_back(e);
    run_tx("chg", n, ab);
    check("chg_words", CHK_W'(n), CHK_W'(MIN_WORDS));

    // te re-asserted on the final tick of the last word: back-to-back word 5.
    code = CW'($urandom); te = 1'b1;
    evq = {};
    evq.push_back(mk_te(1, 1, 1'b0));
    evq.push_back(mk_te(4, int'(WLEN), 1'b1));
    evq.push_back(mk_te(5, 3, 1'b0));
    run_tx("b2b", n, ab);
    check("b2b_words", CHK_W'(n), CHK_W'(5));

    // Asynchronous reset at tick 250 of word 2.
    code = CW'($urandom); te = 1'b1;
    evq = {};
    e = '{word: 2, k: 250, set_te: 1'b0, te_val: 1'b0, set_code: 1'b0,
          code_val: '0, do_rst: 1'b1};
    evq.push_back(e);
    run_tx("rst", n, ab);
    check("rst_aborted", CHK_W'(ab), CHK_W'(1'b1));
    te = 1'b0;
    #3;
    rst = 1'b1;
    idle_ticks("rst_idle", 20);
    code = CW'($urandom); te = 1'b1;
    evq = {}; evq.push_back(mk_te(1, 1, 1'b0));
    run_tx("rst_restart", n, ab);
    check("rst_restart_words", CHK_W'(n), CHK_W'(MIN_WORDS));

    // Random codes, hold lengths and mid-word code changes.
    for (int it = 0; it < 2; it++) begin
      hold  = int'($urandom_range(1, 6));
      exp_n = (hold > int'(MIN_WORDS)) ? hold : int'(MIN_WORDS);
      code  = CW'($urandom); te = 1'b1;
      evq = {};
      evq.push_back(mk_te(hold, int'($urandom_range(1, WLEN)), 1'b0));
      e = '{word: int'($urandom_range(1, 3)), k: int'($urandom_range(1, WLEN)),
            set_te: 1'b0, te_val: 1'b0, set_code: 1'b1,
            code_val: CW'($urandom), do_rst: 1'b0};
      evq.push_back(e);
      run_tx($sformatf("rnd%0d", it), n, ab);
      check($sformatf("rnd%0d_words", it), CHK_W'(n), CHK_W'(exp_n));
    end

    check("wd_single_clk", CHK_W'(wd_stray), CHK_W'(0));
    check("hold_no_tick",  CHK_W'(hold_err), CHK_W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
